// File: rtl/id_pipe_stage.sv
// id_pipe_stage: IF->ID pipeline register with valid/ready handshake and one-entry skid buffer.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 drop every held packet and the packet presented this cycle
//   in_valid/in_ready     fetch-side handshake; in_ready is registered (= !skid valid)
//   in_pc/in_inst         fetch packet
//   out_valid/out_ready   decode-side handshake
//   out_pc/out_inst       decode packet, driven straight from the main register
// Optional: define ID_PIPE_STAGE_PERF_EN to add perf_stall_cnt/perf_bubble_cnt outputs.
module id_pipe_stage #(
    parameter int          PC_W       = 64,
    parameter int          INST_W     = 32,
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
`ifdef ID_PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);
    // state bits are {skid_valid, main_valid}; 2'b10 cannot occur
    typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b11} state_t;
    state_t              state_q, state_d;
    logic [PC_W-1:0]     main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [INST_W-1:0]   main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
    logic                in_fire, out_fire;
    assign in_ready  = !state_q[1];
    assign out_valid = state_q[0];
    assign out_pc    = main_pc_q;
    assign out_inst  = main_inst_q;
    assign in_fire   = in_valid & in_ready & !flush;
    assign out_fire  = out_valid & out_ready;
    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    main_pc_d   = in_pc;
                    main_inst_d = in_inst;
                    state_d     = BUSY;
                end
                BUSY: if (in_fire && out_fire) begin
                    main_pc_d   = in_pc;
                    main_inst_d = in_inst;
                end else if (in_fire) begin
                    skid_pc_d   = in_pc;
                    skid_inst_d = in_inst;
                    state_d     = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
                FULL: if (out_fire) begin
                    main_pc_d   = skid_pc_q;
                    main_inst_d = skid_inst_q;
                    state_d     = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_pc_q   <= PC_W'(RESET_PC);
            main_inst_q <= INST_W'(RESET_INST);
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
        end
    end
    // skid contents are only meaningful while skid valid is set, so no reset
    always_ff @(posedge clk) begin
        skid_pc_q   <= skid_pc_d;
        skid_inst_q <= skid_inst_d;
    end
`ifdef ID_PIPE_STAGE_PERF_EN
    // counters survive flush and wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            perf_stall_cnt  <= perf_stall_cnt + 32'(out_valid & !out_ready);
            perf_bubble_cnt <= perf_bubble_cnt + 32'(!out_valid & out_ready);
        end
    end
`endif
endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: directed self-checking bench for id_pipe_stage.
module tb_id_pipe_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_pc, out_pc;
    logic [31:0] in_inst, out_inst;
    int          total = 0, bad = 0;
`ifdef ID_PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif
    always #5 clk = ~clk;
    id_pipe_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
`ifdef ID_PIPE_STAGE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );
    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return {pc[29:0], 2'b11};
    endfunction
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [63:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst_of(pc);
    endtask
    task automatic expect_out(input string tag, input logic v, input logic rdy, input logic [63:0] pc);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".ready"}, 64'(in_ready), 64'(rdy));
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".inst"}, 64'(out_inst), 64'(pc == 64'h8000_0000 && !v ? 32'h13 : inst_of(pc)));
    endtask
    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 64'h0);
        tick; tick;
        expect_out("reset", 1'b0, 1'b1, 64'h8000_0000);
        rst = 1'b0;
        tick;
        expect_out("idle", 1'b0, 1'b1, 64'h8000_0000);
        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * i));
            tick;
            expect_out($sformatf("stream%0d", i), 1'b1, 1'b1, 64'h8000_0000 + 64'(4 * i));
        end
        drive(1'b0, 64'h0);
        tick;
        check("drain.valid", 64'(out_valid), 64'd0);
        check("drain.pc_hold", out_pc, 64'h8000_0008);
        // backpressure fills the skid buffer
        out_ready = 1'b0;
        drive(1'b1, 64'h100);
        tick;
        expect_out("bp_busy", 1'b1, 1'b1, 64'h100);
        drive(1'b1, 64'h104);
        tick;
        expect_out("bp_full", 1'b1, 1'b0, 64'h100);
        drive(1'b0, 64'h0);
        tick;
        expect_out("bp_hold", 1'b1, 1'b0, 64'h100);
        out_ready = 1'b1;
        tick;
        expect_out("bp_deq1", 1'b1, 1'b1, 64'h104);
        tick;
        check("bp_deq2.valid", 64'(out_valid), 64'd0);
        // flush while full, with a packet presented
        out_ready = 1'b0;
        drive(1'b1, 64'h300);
        tick;
        drive(1'b1, 64'h304);
        tick;
        expect_out("fl_full", 1'b1, 1'b0, 64'h300);
        flush = 1'b1;
        drive(1'b1, 64'h200);
        tick;
        expect_out("flush", 1'b0, 1'b1, 64'h300);
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 64'h0);
        tick;
        check("post_flush.valid", 64'(out_valid), 64'd0);
        check("post_flush.pc", out_pc, 64'h300);
        // reset wins over flush and input while full
        out_ready = 1'b0;
        drive(1'b1, 64'h400);
        tick;
        out_ready = 1'b1;
        drive(1'b1, 64'h404);
        tick;
        out_ready = 1'b0;
        drive(1'b1, 64'h408);
        tick;
        expect_out("rst_full", 1'b1, 1'b0, 64'h404);
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 64'h500);
        tick;
        expect_out("rst_win", 1'b0, 1'b1, 64'h8000_0000);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 64'h0);
        tick;
        check("post_rst.valid", 64'(out_valid), 64'd0);
`ifdef ID_PIPE_STAGE_PERF_EN
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive(1'b1, 64'h600);
        tick;
        drive(1'b0, 64'h0);
        repeat (5) tick;
        check("perf.stall5", 64'(perf_stall_cnt), 64'd5);
        out_ready = 1'b1;
        repeat (3) tick;
        check("perf.stall", 64'(perf_stall_cnt), 64'd5);
        check("perf.bubble", 64'(perf_bubble_cnt), 64'd2);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("perf.no_clear", 64'(perf_bubble_cnt), 64'd3);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
